// File: rtl/sha512_msg_padder_if.sv
// Message-word input stream and padded-block output handshake
// of the sha512 message padder. slave = padder, master = feeder/core side.
`timescale 1ns/1ps
interface sha512_msg_padder_if;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [2:0]    in_bytes;
  logic [1023:0] blk_data;
  logic          blk_valid;
  logic          blk_ready;
  logic          blk_first;
  logic          blk_last;

  modport master (
    output in_data, in_valid, in_last, in_bytes, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last
  );
endinterface

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: 32-bit big-endian words in, padded 1024-bit blocks out.
// Ports: ACLK, ARESET (sync, active-high), bus (slave): in_* word stream, blk_* block handshake.
`timescale 1ns/1ps
module sha512_msg_padder #(
  parameter int LEN_W = 64
) (
  input logic            ACLK,
  input logic            ARESET,
  sha512_msg_padder_if.slave bus
);

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_LEN,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [1023:0]     blk_q, blk_d;
  logic [4:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              extra_q, extra_d;
  logic              pend_q, pend_d;
  logic              init_q;

  logic              rdy;
  logic              acc;
  logic [2:0]        nb;
  logic [9:0]        ofs;
  logic [5:0]        pad_idx;
  logic [127:0]      len128;
  logic [31:0]       len_w;
  logic [31:0]       tail;

  // in_ready held low for one cycle after reset release
  assign rdy     = (state_q == S_FILL) & init_q;
  assign acc     = rdy & bus.in_valid;
  assign nb      = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
  // word idx lives at bit offset (31-idx)*32
  assign ofs     = {~idx_q, 5'b00000};
  // a full last word pushes the 0x80 byte into the next word
  assign pad_idx = {1'b0, idx_q} + {5'd0, (nb == 3'd4)};
  assign len128  = 128'(cnt_q);
  assign len_w   = len128[{~idx_q[1:0], 5'b00000} +: 32];

  always_comb begin
    tail = bus.in_data;
    unique case (nb)
      3'd0:    tail = 32'h8000_0000;
      3'd1:    tail = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    tail = {bus.in_data[31:16], 16'h8000};
      3'd3:    tail = {bus.in_data[31:8], 8'h80};
      default: tail = bus.in_data;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      pend_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      pend_q  <= pend_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    extra_d = extra_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_FILL: begin
        if (acc) begin
          idx_d = idx_q + 5'd1;
          if (!bus.in_last) begin
            blk_d[ofs +: 32] = bus.in_data;
            cnt_d = cnt_q + LEN_W'(32);
            if (idx_q == 5'd31) begin
              state_d = S_OUT;
              last_d  = 1'b0;
              extra_d = 1'b0;
            end
          end else begin
            blk_d[ofs +: 32] = tail;
            cnt_d  = cnt_q + LEN_W'({nb, 3'b000});
            pend_d = (nb == 3'd4);
            if (pad_idx <= 6'd27) begin
              // length fits in words 28..31 of this block
              extra_d = 1'b0;
              state_d = (idx_q == 5'd27) ? S_LEN : S_PAD;
            end else begin
              // length spills into an extra all-pad block
              extra_d = 1'b1;
              last_d  = 1'b0;
              state_d = (idx_q == 5'd31) ? S_OUT : S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        blk_d[ofs +: 32] = pend_q ? 32'h8000_0000 : 32'h0;
        pend_d = 1'b0;
        idx_d  = idx_q + 5'd1;
        if (extra_q) begin
          if (idx_q == 5'd31) begin
            state_d = S_OUT;
            last_d  = 1'b0;
          end
        end else if (idx_q == 5'd27) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        blk_d[ofs +: 32] = len_w;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = S_OUT;
          last_d  = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.blk_ready) begin
          idx_d   = '0;
          blk_d   = '0;
          first_d = last_q;
          if (extra_q) begin
            extra_d = 1'b0;
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
            if (last_q) cnt_d = '0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = rdy;
    bus.blk_valid = (state_q == S_OUT);
    bus.blk_first = (state_q == S_OUT) & first_q;
    bus.blk_last  = (state_q == S_OUT) & last_q;
    bus.blk_data  = blk_q;
  end

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Directed bench for sha512_msg_padder.
// Known vectors, boundary lengths, output stall, back-to-back and mid-message reset.
`timescale 1ns/1ps
module tb_sha512_msg_padder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha512_msg_padder_if bus ();

  sha512_msg_padder #(.LEN_W(64)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic int diff_word(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 32; i++)
      if (a[1023-32*i -: 32] !== b[1023-32*i -: 32]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] wd(input logic [1023:0] a, input int i);
    return a[1023-32*i -: 32];
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hA0B0_C000 + 32'(i);
  endfunction

  function automatic logic [31:0] pat2(input int i);
    return 32'h1100_0000 + 32'(i * 3);
  endfunction

  task automatic push(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_bytes = nb;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_total++;
      $display("FAIL push_timeout: in_ready got 0 want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_block(input int stall, output logic [1023:0] d,
                           output logic f, output logic l, output int cyc);
    logic ok;
    cyc = 0;
    while (!bus.blk_valid && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.blk_valid) begin
      n_total++;
      $display("FAIL blk_timeout: blk_valid got 0 want 1");
    end
    d = bus.blk_data;
    f = bus.blk_first;
    l = bus.blk_last;
    if (stall > 0) begin
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        if (bus.blk_valid !== 1'b1 || bus.blk_data !== d || bus.in_ready !== 1'b0 ||
            bus.blk_first !== f || bus.blk_last !== l) ok = 1'b0;
      end
      n_total++;
      if (!ok) $display("FAIL stall_hold: got unstable/in_ready=%b want stable/in_ready=0",
                        bus.in_ready);
      else n_pass++;
    end
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0)
      $display("FAIL rst_hs: got rdy=%b vld=%b want 0 0", bus.in_ready, bus.blk_valid);
    else n_pass++;
    n_total++;
    if (bus.blk_first !== 1'b0 || bus.blk_last !== 1'b0)
      $display("FAIL rst_fl: got first=%b last=%b want 0 0", bus.blk_first, bus.blk_last);
    else n_pass++;
    n_total++;
    if (bus.blk_data !== 1024'd0)
      $display("FAIL rst_data: got word0 %h want 0", wd(bus.blk_data, 0));
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL rst_rdy_early: got %b want 0", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_rdy_rise: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic chk_blk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    int dw;
    dw = diff_word(got, exp);
    n_total++;
    if (dw >= 0)
      $display("FAIL %s: word %0d got %h want %h", nm, dw, wd(got, dw), wd(exp, dw));
    else n_pass++;
  endtask

  task automatic test_abc();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    push(32'h6162_6300, 1'b1, 3'd3);
    get_block(0, d, f, l, c);
    e = '0;
    e[1023 -: 32] = 32'h6162_6380;
    e[31:0]       = 32'h0000_0018;
    chk_blk("abc_data", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b1) $display("FAIL abc_fl: got %b%b want 11", f, l);
    else n_pass++;
    n_total++;
    if (c !== 31) $display("FAIL abc_lat: got %0d want 31", c);
    else n_pass++;
  endtask

  task automatic test_empty();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    push(32'hDEAD_BEEF, 1'b1, 3'd0);
    get_block(0, d, f, l, c);
    e = '0;
    e[1023 -: 32] = 32'h8000_0000;
    chk_blk("empty_data", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b1) $display("FAIL empty_fl: got %b%b want 11", f, l);
    else n_pass++;
    n_total++;
    if (c !== 31) $display("FAIL empty_lat: got %0d want 31", c);
    else n_pass++;
  endtask

  task automatic test_111();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    e = '0;
    for (int i = 0; i < 27; i++) begin
      push(pat(i), 1'b0, 3'd0);
      e[1023-32*i -: 32] = pat(i);
    end
    push(pat(27), 1'b1, 3'd3);
    e[1023-32*27 -: 32] = 32'hA0B0_C080;
    e[31:0] = 32'h0000_0378;
    get_block(0, d, f, l, c);
    chk_blk("b111_data", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b1) $display("FAIL b111_fl: got %b%b want 11", f, l);
    else n_pass++;
    n_total++;
    if (c !== 4) $display("FAIL b111_lat: got %0d want 4", c);
    else n_pass++;
  endtask

  task automatic test_112();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    e = '0;
    for (int i = 0; i < 27; i++) begin
      push(pat(i), 1'b0, 3'd0);
      e[1023-32*i -: 32] = pat(i);
    end
    push(pat(27), 1'b1, 3'd4);
    e[1023-32*27 -: 32] = pat(27);
    e[1023-32*28 -: 32] = 32'h8000_0000;
    get_block(0, d, f, l, c);
    chk_blk("b112_blk0", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b0) $display("FAIL b112_fl0: got %b%b want 10", f, l);
    else n_pass++;
    get_block(0, d, f, l, c);
    e = '0;
    e[31:0] = 32'h0000_0380;
    chk_blk("b112_blk1", d, e);
    n_total++;
    if (f !== 1'b0 || l !== 1'b1) $display("FAIL b112_fl1: got %b%b want 01", f, l);
    else n_pass++;
  endtask

  task automatic test_bytes_clamp();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    push(32'h1234_5678, 1'b1, 3'd6);
    get_block(0, d, f, l, c);
    e = '0;
    e[1023 -: 32]      = 32'h1234_5678;
    e[1023-32 -: 32]   = 32'h8000_0000;
    e[31:0]            = 32'h0000_0020;
    chk_blk("clamp_data", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b1) $display("FAIL clamp_fl: got %b%b want 11", f, l);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    fork
      begin
        for (int i = 0; i < 32; i++) push(pat2(i), 1'b0, 3'd0);
        push(pat2(32), 1'b1, 3'd4);
        push(32'h6162_6300, 1'b1, 3'd3);
      end
      begin
        get_block(20, d, f, l, c);
        e = '0;
        for (int i = 0; i < 32; i++) e[1023-32*i -: 32] = pat2(i);
        chk_blk("b2b_blk0", d, e);
        n_total++;
        if (f !== 1'b1 || l !== 1'b0) $display("FAIL b2b_fl0: got %b%b want 10", f, l);
        else n_pass++;
        get_block(0, d, f, l, c);
        e = '0;
        e[1023 -: 32]    = pat2(32);
        e[1023-32 -: 32] = 32'h8000_0000;
        e[31:0]          = 32'h0000_0420;
        chk_blk("b2b_blk1", d, e);
        n_total++;
        if (f !== 1'b0 || l !== 1'b1) $display("FAIL b2b_fl1: got %b%b want 01", f, l);
        else n_pass++;
        get_block(0, d, f, l, c);
        e = '0;
        e[1023 -: 32] = 32'h6162_6380;
        e[31:0]       = 32'h0000_0018;
        chk_blk("b2b_msg2", d, e);
        n_total++;
        if (f !== 1'b1 || l !== 1'b1) $display("FAIL b2b_fl2: got %b%b want 11", f, l);
        else n_pass++;
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [1023:0] d, e;
    logic f, l;
    int c;
    for (int i = 0; i < 10; i++) push(pat(i), 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL mid_rst: got vld=%b rdy=%b want 0 0", bus.blk_valid, bus.in_ready);
    else n_pass++;
    rst = 1'b0;
    push(32'h6162_6300, 1'b1, 3'd3);
    get_block(0, d, f, l, c);
    e = '0;
    e[1023 -: 32] = 32'h6162_6380;
    e[31:0]       = 32'h0000_0018;
    chk_blk("mid_data", d, e);
    n_total++;
    if (f !== 1'b1 || l !== 1'b1) $display("FAIL mid_fl: got %b%b want 11", f, l);
    else n_pass++;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = '0;
    bus.blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_111();
    test_112();
    test_bytes_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
